// File: rtl/obi_pkg.sv
//----------------------------------------------------------------------------
// obi_pkg -- OBI configuration record and default request/response channels.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

package obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_default_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_default_rsp_t;

endpackage

`default_nettype wire

// File: rtl/bootrom_copier.sv
//----------------------------------------------------------------------------
// bootrom_copier -- copies SizeBytes from boot ROM to SRAM, one word at a time,
//                   over two OBI manager ports.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module bootrom_copier #(
    parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t = logic,
    parameter type               obi_rsp_t = logic,
    parameter logic [31:0]       SrcAddr   = 32'h0300_D000,
    parameter logic [31:0]       DstAddr   = 32'h1000_0000,
    parameter int unsigned       SizeBytes = 'h1000
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     start_i,
    output logic     busy_o,
    output logic     done_o,
    output logic     err_o,
    output obi_req_t src_req_o,
    input  obi_rsp_t src_rsp_i,
    output obi_req_t dst_req_o,
    input  obi_rsp_t dst_rsp_i
);

    localparam int unsigned c_WORDS = SizeBytes / 4;
    localparam int unsigned c_CNT_W = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam int unsigned c_AW    = ObiCfg.AddrWidth;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        FIN     = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [31:0]          r_data;
    logic                 r_done;
    logic                 r_err;

    logic                 w_start_copy;
    logic                 w_cnt_inc;
    logic                 w_data_ld;
    logic                 w_set_done;
    logic                 w_set_err;
    logic [c_AW-1:0]      w_offset;
    logic [c_AW-1:0]      w_src_addr;
    logic [c_AW-1:0]      w_dst_addr;
    logic                 w_last;
    logic                 w_unused;

    obi_pkg::obi_default_req_t w_src_req;
    obi_pkg::obi_default_req_t w_dst_req;
    obi_pkg::obi_default_rsp_t w_src_rsp;
    obi_pkg::obi_default_rsp_t w_dst_rsp;

    // User response/request types share the default channel layout.
    assign w_src_rsp = obi_pkg::obi_default_rsp_t'(src_rsp_i);
    assign w_dst_rsp = obi_pkg::obi_default_rsp_t'(dst_rsp_i);
    assign src_req_o = obi_req_t'(w_src_req);
    assign dst_req_o = obi_req_t'(w_dst_req);
    assign w_unused  = ^{w_src_rsp.r.rid, w_dst_rsp.r.rdata, w_dst_rsp.r.rid};

    // Address sums wrap at the configured OBI address width.
    assign w_offset   = c_AW'({r_cnt, 2'b00});
    assign w_src_addr = c_AW'(SrcAddr) + w_offset;
    assign w_dst_addr = c_AW'(DstAddr) + w_offset;
    assign w_last     = (r_cnt == c_CNT_W'(c_WORDS - 1));

    always_comb begin
        w_state_next = r_state;
        w_src_req    = '0;
        w_dst_req    = '0;
        w_start_copy = 1'b0;
        w_cnt_inc    = 1'b0;
        w_data_ld    = 1'b0;
        w_set_done   = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            IDLE, FIN: begin
                if (start_i) begin
                    w_start_copy = 1'b1;
                    w_state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                w_src_req.req    = 1'b1;
                w_src_req.a.addr = 32'(w_src_addr);
                w_src_req.a.be   = 4'hF;
                if (w_src_rsp.gnt) begin
                    w_state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (w_src_rsp.rvalid) begin
                    if (w_src_rsp.r.err) begin
                        w_set_err    = 1'b1;
                        w_set_done   = 1'b1;
                        w_state_next = FIN;
                    end else begin
                        w_data_ld    = 1'b1;
                        w_state_next = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                w_dst_req.req     = 1'b1;
                w_dst_req.a.addr  = 32'(w_dst_addr);
                w_dst_req.a.we    = 1'b1;
                w_dst_req.a.be    = 4'hF;
                w_dst_req.a.wdata = r_data;
                if (w_dst_rsp.gnt) begin
                    w_state_next = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (w_dst_rsp.rvalid) begin
                    if (w_dst_rsp.r.err) begin
                        w_set_err    = 1'b1;
                        w_set_done   = 1'b1;
                        w_state_next = FIN;
                    end else if (w_last) begin
                        w_set_done   = 1'b1;
                        w_state_next = FIN;
                    end else begin
                        w_cnt_inc    = 1'b1;
                        w_state_next = RD_REQ;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start_copy) begin
                r_cnt  <= '0;
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end else begin
                if (w_cnt_inc)  r_cnt  <= r_cnt + 1'b1;
                if (w_set_done) r_done <= 1'b1;
                if (w_set_err)  r_err  <= 1'b1;
            end
            if (w_data_ld) begin
                r_data <= w_src_rsp.r.rdata;
            end
        end
    end

    assign busy_o = (r_state == RD_REQ) || (r_state == RD_WAIT) ||
                    (r_state == WR_REQ) || (r_state == WR_WAIT);
    assign done_o = r_done;
    assign err_o  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bootrom_copier.sv
//----------------------------------------------------------------------------
// tb_bootrom_copier -- randomized ROM/SRAM slaves with a word-level copy model.
//----------------------------------------------------------------------------
`default_nettype none

module tb_bootrom_copier;

    localparam logic [31:0] SRC   = 32'h0300_D000;
    localparam logic [31:0] DST   = 32'h1000_0000;
    localparam int          WORDS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, err;

    obi_pkg::obi_default_req_t src_req, dst_req;
    obi_pkg::obi_default_rsp_t src_rsp = '0;
    obi_pkg::obi_default_rsp_t dst_rsp = '0;
    obi_pkg::obi_a_chan_t      exp_a;

    bootrom_copier #(
        .ObiCfg    (obi_pkg::ObiDefaultConfig),
        .obi_req_t (obi_pkg::obi_default_req_t),
        .obi_rsp_t (obi_pkg::obi_default_rsp_t),
        .SrcAddr   (SRC),
        .DstAddr   (DST),
        .SizeBytes (16)
    ) u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .src_req_o (src_req),
        .src_rsp_i (src_rsp),
        .dst_req_o (dst_req),
        .dst_rsp_i (dst_rsp)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [WORDS];
    int src_gst [WORDS];
    int src_rdl [WORDS];
    int dst_gst [WORDS];
    int dst_rdl [WORDS];
    int err_word = -1;
    int rd_cnt = 0, wr_cnt = 0, extra = 0;
    int src_wait = 0, dst_wait = 0, src_pidx = 0, src_dly = 0, dst_dly = 0;
    bit src_pend = 0, dst_pend = 0;
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ROM and SRAM slaves: responses are set up on the falling edge for the next rising edge.
    always @(negedge clk) begin
        src_rsp = '0;
        dst_rsp = '0;
        if (!rst_n) begin
            src_pend = 0; dst_pend = 0; src_wait = 0; dst_wait = 0;
            rd_cnt = 0; wr_cnt = 0;
        end else begin
            check("excl", {71'b0, src_req.req & dst_req.req}, 72'b0);
            if (src_pend) begin
                if (src_dly > 0) begin
                    src_dly--; extra++;
                end else begin
                    src_rsp.rvalid  = 1'b1;
                    src_rsp.r.rdata = rom[src_pidx];
                    src_rsp.r.err   = (src_pidx == err_word);
                    src_pend = 0;
                end
            end
            if (src_req.req) begin
                int i;
                i = (rd_cnt < WORDS) ? rd_cnt : 0;
                exp_a       = '0;
                exp_a.addr  = SRC + 32'(4 * rd_cnt);
                exp_a.be    = 4'hF;
                check("src_a", 72'(src_req.a), 72'(exp_a));
                if (src_wait < src_gst[i]) begin
                    src_wait++; extra++;
                end else begin
                    src_rsp.gnt = 1'b1;
                    src_wait = 0; src_pend = 1; src_pidx = i; src_dly = src_rdl[i];
                    rd_cnt++;
                end
            end
            if (dst_pend) begin
                if (dst_dly > 0) begin
                    dst_dly--; extra++;
                end else begin
                    dst_rsp.rvalid = 1'b1;
                    dst_pend = 0;
                end
            end
            if (dst_req.req) begin
                int i;
                i = (wr_cnt < WORDS) ? wr_cnt : 0;
                exp_a       = '0;
                exp_a.addr  = DST + 32'(4 * wr_cnt);
                exp_a.we    = 1'b1;
                exp_a.be    = 4'hF;
                exp_a.wdata = rom[i];
                check("dst_a", 72'(dst_req.a), 72'(exp_a));
                if (dst_wait < dst_gst[i]) begin
                    dst_wait++; extra++;
                end else begin
                    dst_rsp.gnt = 1'b1;
                    dst_wait = 0; dst_pend = 1; dst_dly = dst_rdl[i];
                    wr_cnt++;
                end
            end
        end
    end

    task automatic clear_stalls();
        for (int i = 0; i < WORDS; i++) begin
            src_gst[i] = 0; src_rdl[i] = 0; dst_gst[i] = 0; dst_rdl[i] = 0;
        end
        err_word = -1;
    endtask

    task automatic pulse_start();
        rd_cnt = 0; wr_cnt = 0; extra = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Expected length: 4 cycles per completed word, 2 for an aborted read, plus injected stalls.
    task automatic run_copy(input string tag, input int exp_writes, input bit exp_err, input int mid_pulse);
        int cyc;
        int expc;
        bit dn;
        cyc = 0; dn = 0;
        pulse_start();
        while (!dn && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == mid_pulse);
            if (cyc == 1) check({tag, "_clr"}, {69'b0, busy, done, err}, {69'b0, 3'b100});
            dn = done;
        end
        start = 1'b0;
        expc = exp_err ? (4 * exp_writes + 2 + extra) : (4 * WORDS + extra);
        check({tag, "_cyc"},    72'(cyc), 72'(expc));
        check({tag, "_flags"},  {69'b0, busy, done, err}, {69'b0, 1'b0, 1'b1, exp_err});
        check({tag, "_writes"}, 72'(wr_cnt), 72'(exp_writes));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_flags"}, {69'b0, busy, done, err}, 72'b0);
        check({tag, "_src"},   72'(src_req), 72'b0);
        check({tag, "_dst"},   72'(dst_req), 72'b0);
    endtask

    initial begin
        int k;
        clear_stalls();
        for (int i = 0; i < WORDS; i++) rom[i] = 32'h11 * (i + 1);

        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("post_reset");

        run_copy("basic", 4, 0, 0);

        dst_gst[1] = 3;
        run_copy("dst_stall", 4, 0, 0);
        clear_stalls();

        err_word = 2;
        run_copy("src_err", 2, 1, 0);
        err_word = -1;

        for (int i = 0; i < WORDS; i++) rom[i] = $urandom;
        run_copy("restart_mid", 4, 0, 6);

        pulse_start();
        k = 0;
        while (wr_cnt < 2 && k < 100) begin
            @(posedge clk);
            #1 k++;
        end
        check("rst_reach", 72'(wr_cnt), 72'd2);
        rst_n = 1'b0;
        #1 check_idle_outputs("rst_mid");
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("rst_hold");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("rst_idle");
        run_copy("after_rst", 4, 0, 0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < WORDS; i++) begin
                rom[i]     = $urandom;
                src_gst[i] = $urandom_range(0, 2);
                src_rdl[i] = $urandom_range(0, 2);
                dst_gst[i] = $urandom_range(0, 2);
                dst_rdl[i] = $urandom_range(0, 2);
            end
            err_word = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1;
            if (err_word >= 0) run_copy("rand_err", err_word, 1, 0);
            else               run_copy("rand", 4, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bootrom_copier.md
BOOTROM_COPIER -- requirements
Module: bootrom_copier

Interface
REQ-001 SHALL have parameter ObiCfg, default obi_pkg::ObiDefaultConfig, the OBI configuration shared by both manager ports.
REQ-002 SHALL have parameter obi_req_t, default logic, the OBI request struct.
REQ-003 SHALL have parameter obi_rsp_t, default logic, the OBI response struct.
REQ-004 SHALL have parameter SrcAddr, default 32'h0300_D000, the boot ROM base address.
REQ-005 SHALL have parameter DstAddr, default 32'h1000_0000, the SRAM destination base address.
REQ-006 SHALL have parameter SizeBytes, default 'h1000, the copy length; it is a multiple of 4 and at least 4.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-008 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port start_i, input, 1 bit: a pulse that starts a copy.
REQ-010 SHALL have port busy_o, output, 1 bit: high while a copy is in progress.
REQ-011 SHALL have port done_o, output, 1 bit: sticky copy-finished flag.
REQ-012 SHALL have port err_o, output, 1 bit: sticky flag that the copy aborted on an OBI error.
REQ-013 SHALL have port src_req_o, output, obi_req_t: OBI manager request to the boot ROM.
REQ-014 SHALL have port src_rsp_i, input, obi_rsp_t: OBI response from the boot ROM.
REQ-015 SHALL have port dst_req_o, output, obi_req_t: OBI manager request to SRAM.
REQ-016 SHALL have port dst_rsp_i, input, obi_rsp_t: OBI response from SRAM.

Function
REQ-017 SHALL implement the FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT and FIN.
REQ-018 SHALL move from IDLE or FIN to RD_REQ on start_i=1, clearing the word counter, done_o and err_o.
REQ-019 SHALL ignore start_i in every state other than IDLE and FIN.
REQ-020 SHALL, in RD_REQ, drive src req=1, we=0, be='1, aid=0, addr=SrcAddr+4*cnt, with all other fields '0.
REQ-021 SHALL hold the src request fields stable until gnt, then enter RD_WAIT.
REQ-022 SHALL, in RD_WAIT, drive src req=0 and wait for rvalid.
REQ-023 SHALL, on the rvalid cycle with r.err=0, register r.rdata and enter WR_REQ.
REQ-024 SHALL, on the rvalid cycle with r.err=1, set err_o and enter FIN.
REQ-025 SHALL, in WR_REQ, drive dst req=1, we=1, be='1, aid=0, addr=DstAddr+4*cnt and wdata=the registered word.
REQ-026 SHALL hold the dst request fields stable until gnt, then enter WR_WAIT.
REQ-027 SHALL, in WR_WAIT, drive dst req=0 and wait for rvalid.
REQ-028 SHALL, when dst rvalid has r.err=1, set err_o and enter FIN.
REQ-029 SHALL, when dst rvalid has r.err=0 and cnt=SizeBytes/4-1, enter FIN.
REQ-030 SHALL, when dst rvalid has r.err=0 and cnt<SizeBytes/4-1, increment cnt and enter RD_REQ.
REQ-031 SHALL set done_o on entry to FIN, whether the copy completed or aborted.
REQ-032 SHALL drive busy_o=1 exactly in RD_REQ, RD_WAIT, WR_REQ and WR_WAIT.
REQ-033 SHALL keep at most one transaction outstanding per port and never assert both req outputs in the same cycle.
REQ-034 SHALL take 4 cycles per word with same-cycle gnt and next-cycle rvalid, plus 1 cycle per stalled gnt or rvalid cycle.
REQ-035 SHALL size cnt at $clog2(SizeBytes/4) bits, minimum 1, and compute address sums at ObiCfg.AddrWidth bits with wrap-around.

Reset
REQ-036 SHALL, on rst_ni low, asynchronously enter IDLE and clear cnt, the data register, busy_o, done_o, err_o and both req outputs.
REQ-037 SHALL abandon a copy interrupted by reset; after release the block stays in IDLE until start_i.

Structure
REQ-038 SHALL keep the state enum local to the module; no new shared package entry is needed beyond obi_pkg.
REQ-039 SHALL be flat, with no sub-module.

Verification
REQ-040 SHALL cover: SizeBytes=16, ROM words 0x11..0x44, immediate gnt/rvalid, start pulse -> 4 writes to 0x1000_0000..0x1000_000C with matching data, done_o=1 at cycle 16, busy_o=0.
REQ-041 SHALL cover: dst gnt stalled 3 cycles on word 1 -> dst addr/wdata stable during the stall, total 19 cycles, data correct.
REQ-042 SHALL cover: src r.err=1 on word 2 -> exactly 2 writes issued, then err_o=1, done_o=1, busy_o=0.
REQ-043 SHALL cover: rst_ni low during WR_WAIT of word 1, then start -> all outputs 0 during reset, and the new copy restarts at word 0.
REQ-044 SHALL cover: start_i pulsed mid-copy and again in FIN -> the mid-copy pulse is ignored; the FIN pulse clears done_o/err_o and re-copies.
